// File: rtl/mem_responder_pkg.sv
// Shared widths and FSM encoding for the
// 36-bit word memory responder.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 36;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Offset lies inside a window of 2^bits words.
  function automatic logic in_window(
    input logic [ADDR_W-1:0] off,
    input int unsigned       bits
  );
    return (off >> bits) == '0;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM, one read/write port.
// Ports: clk, en, we, addr, wdata -> q (registered read).
module mem_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    q
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_BITS)-1];

  // q only moves on a read, so it keeps the
  // word fetched at acceptance through a write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory slave: decodes a 2^ADDR_BITS window
// at BASE, inserts LATENCY wait cycles per access.
// Ports: clk, reset (sync, high), s_address, s_write,
//   s_read, s_writedata -> s_readdata, s_waitrequest, nxm.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE      = 18'o000000,
  parameter int unsigned       ADDR_BITS = 14,
  parameter int unsigned       LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_write,
  input  logic              s_read,
  input  logic [WORD_W-1:0] s_writedata,
  output logic [WORD_W-1:0] s_readdata,
  output logic              s_waitrequest,
  output logic              nxm
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic                 req;
  logic                 accept;
  logic [ADDR_W-1:0]    off_live;
  logic                 hit_live;
  logic [ADDR_BITS-1:0] idx_live;

  logic [ADDR_BITS-1:0] idx_q;
  logic                 hit_q;
  logic                 wr_q;
  logic                 rd_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WORD_W-1:0]    hold_q;

  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WORD_W-1:0]    ram_q;
  logic [WORD_W-1:0]    done_data;

  assign req      = s_read | s_write;
  assign accept   = (state == IDLE) && req;
  assign off_live = s_address - BASE;
  assign hit_live = in_window(off_live, ADDR_BITS);
  assign idx_live = off_live[ADDR_BITS-1:0];

  // Read happens at acceptance from the live
  // address; the write lands at the DONE edge.
  assign ram_we   = (state == DONE) && wr_q
                    && hit_q && !reset;
  assign ram_en   = (accept && hit_live) || ram_we;
  assign ram_addr = (state == IDLE) ? idx_live : idx_q;

  assign done_data = hit_q ? ram_q : '0;

  mem_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        idx_q   <= idx_live;
        hit_q   <= hit_live;
        wr_q    <= s_write;
        rd_q    <= s_read;
        wdata_q <= s_writedata;
      end
      if (state == DONE && (wr_q || rd_q)) begin
        hold_q <= done_data;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    s_waitrequest = 1'b1;
    nxm           = 1'b0;
    s_readdata    = hold_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LAT == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
            cnt_nx   = LAT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nx      = IDLE;
        s_waitrequest = 1'b0;
        nxm           = !hit_q;
        s_readdata    = done_data;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with
// different BASE/ADDR_BITS/LATENCY against a model.
module tb_mem_responder;

  typedef struct {
    int          cyc;
    logic [35:0] d;
    bit          nx;
    bit          kn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic [17:0] addr  [3];
  logic        wr    [3];
  logic        rd    [3];
  logic [35:0] wdata [3];
  logic [35:0] rdata [3];
  logic        wreq  [3];
  logic        nxm   [3];

  int          lat  [3] = '{2, 0, 3};
  int          ab   [3] = '{14, 4, 14};
  logic [17:0] base [3] = '{18'o0, 18'o0, 18'o040000};

  int          cyc = 0;
  bit          run = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t        eq [3][$];
  logic [35:0] mdl [int];
  logic [35:0] hold   [3];
  bit          hknown [3];
  int          obs_done [3];
  int          obs_cnt  [3];
  int          obs_nxm  [3];

  mem_responder #(
    .BASE(18'o0), .ADDR_BITS(14), .LATENCY(2)
  ) u0 (
    .clk(clk), .reset(rst[0]),
    .s_address(addr[0]), .s_write(wr[0]),
    .s_read(rd[0]), .s_writedata(wdata[0]),
    .s_readdata(rdata[0]),
    .s_waitrequest(wreq[0]), .nxm(nxm[0])
  );

  mem_responder #(
    .BASE(18'o0), .ADDR_BITS(4), .LATENCY(0)
  ) u1 (
    .clk(clk), .reset(rst[1]),
    .s_address(addr[1]), .s_write(wr[1]),
    .s_read(rd[1]), .s_writedata(wdata[1]),
    .s_readdata(rdata[1]),
    .s_waitrequest(wreq[1]), .nxm(nxm[1])
  );

  mem_responder #(
    .BASE(18'o040000), .ADDR_BITS(14), .LATENCY(3)
  ) u2 (
    .clk(clk), .reset(rst[2]),
    .s_address(addr[2]), .s_write(wr[2]),
    .s_read(rd[2]), .s_writedata(wdata[2]),
    .s_readdata(rdata[2]),
    .s_waitrequest(wreq[2]), .nxm(nxm[2])
  );

  task automatic chk(input string nm, input int k,
                     input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %0o want %0o",
               nm, k, cyc, act, exp);
    end
  endtask

  function automatic bit in_rng(input int k,
                                input logic [17:0] a);
    logic [17:0] off;
    off = a - base[k];
    return int'(off) < (1 << ab[k]);
  endfunction

  // Model: a completion lands LATENCY+1 edges after
  // the request is driven; reset wipes pending work.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        eq[k].delete();
        hold[k]   = '0;
        hknown[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        while (eq[k].size() > 0 && eq[k][0].cyc < cyc)
          void'(eq[k].pop_front());
        if (eq[k].size() > 0 && eq[k][0].cyc == cyc) begin
          chk("wait_low", k, 36'(wreq[k]), 36'd0);
          chk("nxm", k, 36'(nxm[k]), 36'(eq[k][0].nx));
          if (eq[k][0].kn)
            chk("rd_done", k, rdata[k], eq[k][0].d);
          hold[k]   = eq[k][0].d;
          hknown[k] = eq[k][0].kn;
          void'(eq[k].pop_front());
        end else begin
          chk("wait_high", k, 36'(wreq[k]), 36'd1);
          chk("nxm_idle", k, 36'(nxm[k]), 36'd0);
          if (hknown[k])
            chk("rd_hold", k, rdata[k], hold[k]);
        end
        if (!wreq[k]) begin
          obs_done[k] = cyc;
          obs_cnt[k]++;
        end
        if (nxm[k]) obs_nxm[k]++;
      end
    end
  end

  task automatic access(input int k,
                        input logic [17:0] a,
                        input logic w, input logic r,
                        input logic [35:0] d,
                        output int n);
    exp_t e;
    bit   hit;
    int   key;
    hit   = in_rng(k, a);
    key   = (k << 18) | int'(a);
    n     = cyc;
    e.cyc = n + lat[k] + 1;
    e.nx  = !hit;
    e.kn  = !hit || mdl.exists(key);
    e.d   = (hit && mdl.exists(key)) ? mdl[key] : '0;
    eq[k].push_back(e);
    if (w && hit) mdl[key] = d;
    addr[k]  = a;
    wr[k]    = w;
    rd[k]    = r;
    wdata[k] = d;
    repeat (lat[k] + 2) @(posedge clk);
    #1;
    wr[k] = 1'b0;
    rd[k] = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int c0;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; addr[k] = '0; wr[k] = 1'b0;
      rd[k] = 1'b0; wdata[k] = '0;
      hold[k] = '0; hknown[k] = 1'b1;
      obs_done[k] = 0; obs_cnt[k] = 0; obs_nxm[k] = 0;
    end
    @(posedge clk);
    #1;
    run = 1;
    @(negedge clk);
    chk("rst_wait", 0, 36'(wreq[0]), 36'd1);
    chk("rst_rd", 0, rdata[0], 36'd0);
    chk("rst_nxm", 0, 36'(nxm[0]), 36'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    idle(1);

    c0 = obs_cnt[0];
    access(0, 18'o100, 1, 0, 36'o123456701234, n);
    chk("lat2_done", 0, 36'(obs_done[0] - n), 36'd3);
    chk("lat2_once", 0, 36'(obs_cnt[0] - c0), 36'd1);
    access(0, 18'o100, 0, 1, '0, n);
    @(negedge clk);
    chk("rd_100", 0, rdata[0], 36'o123456701234);
    access(0, 18'o037777, 1, 0, 36'o444, n);
    access(0, 18'o037777, 0, 1, '0, n);
    @(negedge clk);
    chk("rd_top", 0, rdata[0], 36'o444);
    access(0, 18'o040000, 0, 1, '0, n);
    @(negedge clk);
    chk("oor_rd", 0, rdata[0], 36'd0);

    access(1, 18'o5, 1, 0, 36'o7, n);
    access(1, 18'o5, 1, 1, 36'o1, n);
    @(negedge clk);
    chk("rpw_old", 1, rdata[1], 36'o7);
    access(1, 18'o5, 0, 1, '0, n);
    @(negedge clk);
    chk("rpw_new", 1, rdata[1], 36'o1);
    c0 = obs_cnt[1];
    n  = cyc;
    e.d = 36'o1; e.nx = 0; e.kn = 1;
    e.cyc = n + 1; eq[1].push_back(e);
    e.cyc = n + 3; eq[1].push_back(e);
    addr[1] = 18'o5; rd[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd[1] = 1'b0;
    idle(1);
    chk("held_twice", 1, 36'(obs_cnt[1] - c0), 36'd2);
    access(1, 18'o17, 1, 0, 36'o3, n);
    access(1, 18'o20, 1, 1, 36'o5, n);
    access(1, 18'o17, 0, 1, '0, n);

    access(2, 18'o040010, 1, 0, 36'o2525, n);
    access(2, 18'o040010, 0, 1, '0, n);
    @(negedge clk);
    chk("win_rd", 2, rdata[2], 36'o2525);
    c0 = obs_nxm[2];
    access(2, 18'o000010, 0, 1, '0, n);
    @(negedge clk);
    chk("oor_zero", 2, rdata[2], 36'd0);
    chk("nxm_pulse", 2, 36'(obs_nxm[2] - c0), 36'd1);
    access(2, 18'o000010, 1, 0, 36'o7777, n);
    access(2, 18'o037777, 0, 1, '0, n);
    access(2, 18'o077777, 1, 0, 36'o31, n);
    access(2, 18'o100000, 0, 1, '0, n);
    access(2, 18'o040010, 0, 1, '0, n);
    @(negedge clk);
    chk("oor_nowr", 2, rdata[2], 36'o2525);

    access(2, 18'o040020, 1, 0, 36'o55, n);
    c0 = obs_cnt[2];
    addr[2] = 18'o040020; wdata[2] = 36'o66;
    wr[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr[2] = 1'b0;
    idle(3);
    chk("drop_none", 2, 36'(obs_cnt[2] - c0), 36'd0);
    access(2, 18'o040020, 0, 1, '0, n);
    @(negedge clk);
    chk("drop_keep", 2, rdata[2], 36'o55);

    addr[2] = 18'o040020; wdata[2] = 36'o77;
    wr[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b1; wr[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("rst_w_wait", 2, 36'(wreq[2]), 36'd1);
    chk("rst_w_rd", 2, rdata[2], 36'd0);
    access(2, 18'o040020, 0, 1, '0, n);
    @(negedge clk);
    chk("rst_nowr", 2, rdata[2], 36'o55);

    idle(3);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
